demux1to4_buf: RTL
==================

Name: demux1to4_buf

Overview:
- One-to-four pipelined demultiplexer; the distribution-side counterpart of the datapath 4:1 selectors.
- Routes one producer stream to one of four consumer channels, chosen per transfer by a 2-bit select (same encoding as the 4:1 select: 00→ch0, 01→ch1, 10→ch2, 11→ch3).
- Each output channel has a one-entry registered holding slot with valid/ready handshake.
- Sits between a pipeline stage result and its four downstream consumers (e.g. write-back/forward targets) to decouple their stalls.

Parameters:
- WIDTH, 32, data width of the input and of each output channel.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a transfer.
- in_ready  output  1  block can accept the offered transfer this cycle.
- in_sel  input  2  destination channel of the offered transfer.
- in_data  input  WIDTH  payload.
- out_valid  output  4  bit k: channel k slot holds data.
- out_ready  input  4  bit k: consumer k takes data this cycle.
- out_data0  output  WIDTH  channel 0 slot contents.
- out_data1  output  WIDTH  channel 1 slot contents.
- out_data2  output  WIDTH  channel 2 slot contents.
- out_data3  output  WIDTH  channel 3 slot contents.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset is asynchronous and active-high; one clock domain (clk).
- Reset (asserted, any time incl. mid-transfer): all slots emptied; out_valid=4'b0000, out_data0..3=0, busy=0. Slot contents are discarded and nothing is delivered after reset.
- Per channel k: full[k] register, data[k] register; out_valid[k]=full[k]; out_data k = data[k].
- Handshakes:
  - pop[k] = full[k] & out_ready[k].
  - push = in_valid & in_ready, targeting channel in_sel.
- in_ready = ~full[in_sel] | out_ready[in_sel]. Combinational from in_sel/out_ready, independent of in_valid.
  - No combinational path from in_data to any output.
  - No path from in_valid to in_ready.
- Slot next-state per channel k, on the clock edge:
  - push to k, no pop: full←1, data←in_data.
  - push to k and pop k same cycle: full stays 1, data←in_data. The old entry is delivered and the new one is captured, giving full throughput of 1 transfer/cycle per channel.
  - pop only: full←0, data holds its value (don't-care, not cleared).
  - neither: hold.
- Latency: data accepted in cycle N is visible on out_data/out_valid in cycle N+1.
- Ordering: per channel, strict FIFO order (single entry). No ordering guarantee across channels.
- Pops on different channels are independent and may occur in the same cycle as a push to another channel.
- Backpressure: if channel in_sel is full and its out_ready=0, then in_ready=0 and the producer must hold in_valid/in_sel/in_data stable until acceptance.
  - Other channels keep draining meanwhile.
  - Head-of-line blocking on the input is intended.
- out_ready while out_valid=0: ignored, no state change.
- in_valid=0: no state change from the input side, regardless of in_ready.
- busy = |out_valid (combinational from registers).

Test Plan:
- Reset then idle → out_valid=0000, busy=0, out_data0..3=0. With in_sel=2 and all out_ready=0, in_ready=1.
- Routing: push 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 on consecutive cycles, all out_ready=1 → each appears one cycle after acceptance on the matching channel only; in_ready=1 throughout.
- Backpressure: out_ready=0000, push 0x11 to ch1 → out_valid=0010. Next offer 0x22 to ch1 → in_ready=0, held 3 cycles. Raise out_ready[1] → 0x11 delivered, 0x22 accepted the same cycle and visible next cycle.
- Simultaneous: ch2 full with 0x55, out_ready[2]=1, push 0x66 to ch2 and 0x77 offered next cycle → back-to-back delivery 0x55,0x66,0x77, no bubble.
- Cross-channel: ch0 full and stalled while pushing 0x33 to ch3 → accepted, ch0 data unchanged. Then offer to ch0 → in_ready=0.
- Async reset mid-operation: slots 0 and 2 full, assert rst between clock edges → out_valid=0000 and busy=0 immediately without a clock edge; after release, the next push behaves as from idle.

Source files
------------

// File: rtl/demux1to4_buf.sv
// One-to-four demultiplexer with a one-entry registered slot per output channel.
// Each slot uses a valid/ready handshake, so a full slot can be refilled in the cycle it drains.
module demux1to4_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
);

    logic [3:0]            full;
    logic [3:0][WIDTH-1:0] data;
    logic [3:0]            push;
    logic [3:0]            pop;

    // in_ready looks only at the selected slot, so a stall on one channel blocks the input.
    always_comb begin
        push     = 4'b0000;
        in_ready = ~full[in_sel] | out_ready[in_sel];
        if (in_valid && in_ready) begin
            push[in_sel] = 1'b1;
        end
        pop = full & out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 4'b0000;
            data <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    full[k] <= 1'b1;
                    data[k] <= in_data;
                end else if (pop[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full;
    assign out_data0 = data[0];
    assign out_data1 = data[1];
    assign out_data2 = data[2];
    assign out_data3 = data[3];
    assign busy      = |full;

endmodule
